systolic_pe_os: RTL and testbench

// - Parametrised output-stationary systolic PE: next-generation array cell with operand valids,

---
 rtl/systolic_pe_os_pkg.sv | 39 +++
 rtl/systolic_pe_os_if.sv | 43 ++++
 rtl/systolic_pe_os_mul_pipe.sv | 54 +++++
 rtl/systolic_pe_os.sv | 168 ++++++++++++++++
 tb/tb_systolic_pe_os.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pe_os_pkg.sv
// Shared definitions for the output-stationary systolic PE: default widths,
// multiplier latency bounds, pipeline tag type, accumulator actions and
// the signed-overflow helper shared with the array wrapper.
package systolic_pe_os_pkg;

  localparam int unsigned DEF_A_W     = 8;
  localparam int unsigned DEF_B_W     = 8;
  localparam int unsigned DEF_ACC_W   = 24;
  localparam int unsigned DEF_MUL_LAT = 1;
  // Legal multiplier pipeline depth range.
  localparam int unsigned MUL_LAT_MIN = 1;
  localparam int unsigned MUL_LAT_MAX = 4;

  // Tag travelling alongside each product through the multiplier pipeline.
  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  // Action taken by the accumulator stage in a given cycle.
  typedef enum logic [1:0] {
    ACC_HOLD,
    ACC_ADD,
    ACC_TILE_END,
    ACC_FLUSH
  } acc_op_e;

  // Two's-complement add overflow from the operand and result sign bits.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                   input logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction

  // True when a multiplier depth lies in the supported range.
  function automatic logic mul_lat_ok(input int unsigned lat);
    return (lat >= MUL_LAT_MIN) && (lat <= MUL_LAT_MAX);
  endfunction

endpackage

// File: rtl/systolic_pe_os_if.sv
// PE boundary bundle: west/north operand inputs, east/south forwarded
// operands, flush control, result and error outputs.
interface systolic_pe_os_if
  import systolic_pe_os_pkg::*;
#(
  parameter int unsigned A_W   = DEF_A_W,
  parameter int unsigned B_W   = DEF_B_W,
  parameter int unsigned ACC_W = DEF_ACC_W
);

  logic                    clr;
  logic signed [A_W-1:0]   a_in;
  logic                    a_vld_in;
  logic                    a_last_in;
  logic signed [B_W-1:0]   b_in;
  logic                    b_vld_in;

  logic signed [A_W-1:0]   a_out;
  logic                    a_vld_out;
  logic                    a_last_out;
  logic signed [B_W-1:0]   b_out;
  logic                    b_vld_out;

  logic signed [ACC_W-1:0] res_out;
  logic                    res_vld;
  logic                    res_sat;
  logic                    err_mis;

  // Upstream side: feeds operands and flush, observes everything the PE emits.
  modport master (
    output clr, a_in, a_vld_in, a_last_in, b_in, b_vld_in,
    input  a_out, a_vld_out, a_last_out, b_out, b_vld_out,
    input  res_out, res_vld, res_sat, err_mis
  );

  // PE side.
  modport slave (
    input  clr, a_in, a_vld_in, a_last_in, b_in, b_vld_in,
    output a_out, a_vld_out, a_last_out, b_out, b_vld_out,
    output res_out, res_vld, res_sat, err_mis
  );

endinterface

// File: rtl/systolic_pe_os_mul_pipe.sv
// MUL_LAT-stage signed multiplier with a matching vld/last tag shift
// register. A synchronous flush kills every in-flight tag; product data is
// left in place since it is never consumed without a valid tag.
// MUL_LAT must lie in MUL_LAT_MIN..MUL_LAT_MAX.
module pe_mul_pipe
  import systolic_pe_os_pkg::*;
#(
  parameter int unsigned A_W     = DEF_A_W,
  parameter int unsigned B_W     = DEF_B_W,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      vld_i,
  input  logic                      last_i,
  input  logic signed [A_W-1:0]     a_i,
  input  logic signed [B_W-1:0]     b_i,
  output logic signed [A_W+B_W-1:0] p_o,
  output logic                      vld_o,
  output logic                      last_o
);

  localparam int unsigned PW = A_W + B_W;

  logic signed [PW-1:0] prod_q [MUL_LAT];
  tag_t                 tag_q  [MUL_LAT];

  // Product and tag shift register; stage 0 captures the issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        prod_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (flush_i) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      prod_q[0] <= PW'(a_i) * PW'(b_i);
      tag_q[0]  <= tag_t'{vld: vld_i, last: vld_i & last_i};
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        prod_q[i] <= prod_q[i-1];
        tag_q[i]  <= tag_q[i-1];
      end
    end
  end

  assign p_o    = prod_q[MUL_LAT-1];
  assign vld_o  = tag_q[MUL_LAT-1].vld;
  assign last_o = tag_q[MUL_LAT-1].last;

endmodule

// File: rtl/systolic_pe_os.sv
// Output-stationary systolic PE: forwards operands east/south with one
// cycle of delay, multiplies matched operand pairs, accumulates with
// optional saturation and emits one self-clearing result per tile.
module systolic_pe_os
  import systolic_pe_os_pkg::*;
#(
  parameter int unsigned A_W     = DEF_A_W,
  parameter int unsigned B_W     = DEF_B_W,
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter bit          SAT_EN  = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  systolic_pe_os_if.slave pe
);

  localparam int unsigned PW = A_W + B_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // ---------------- operand forwarding ----------------
  logic signed [A_W-1:0] a_q;
  logic                  a_vld_q;
  logic                  a_last_q;
  logic signed [B_W-1:0] b_q;
  logic                  b_vld_q;

  // One-cycle operand forwarding, untouched by clr or MAC activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      a_vld_q  <= 1'b0;
      a_last_q <= 1'b0;
      b_q      <= '0;
      b_vld_q  <= 1'b0;
    end else begin
      a_q      <= pe.a_in;
      a_vld_q  <= pe.a_vld_in;
      a_last_q <= pe.a_last_in;
      b_q      <= pe.b_in;
      b_vld_q  <= pe.b_vld_in;
    end
  end

  assign pe.a_out      = a_q;
  assign pe.a_vld_out  = a_vld_q;
  assign pe.a_last_out = a_last_q;
  assign pe.b_out      = b_q;
  assign pe.b_vld_out  = b_vld_q;

  // ---------------- issue and multiplier ----------------
  logic                 issue;
  logic                 mis;
  logic signed [PW-1:0] p;
  logic                 p_vld;
  logic                 p_last;

  assign issue = pe.a_vld_in & pe.b_vld_in;
  assign mis   = pe.a_vld_in ^ pe.b_vld_in;

  // clr also flushes the multiplier, which covers an issue in the clr cycle.
  pe_mul_pipe #(
    .A_W    (A_W),
    .B_W    (B_W),
    .MUL_LAT(MUL_LAT)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(pe.clr),
    .vld_i  (issue),
    .last_i (pe.a_last_in),
    .a_i    (pe.a_in),
    .b_i    (pe.b_in),
    .p_o    (p),
    .vld_o  (p_vld),
    .last_o (p_last)
  );

  // ---------------- accumulator stage ----------------
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    tile_sat_q, tile_sat_d;
  logic signed [ACC_W-1:0] res_q, res_d;
  logic                    res_sat_q, res_sat_d;
  logic                    res_vld_q, res_vld_d;
  logic                    err_q, err_d;

  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] sum_raw;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic                    sat_hit;
  acc_op_e                 acc_op;

  // Adder with optional clamp, and selection of the accumulator action.
  always_comb begin
    p_ext   = ACC_W'(p);
    sum_raw = acc_q + p_ext;
    ovf     = add_ovf(acc_q[ACC_W-1], p_ext[ACC_W-1], sum_raw[ACC_W-1]);
    sat_hit = SAT_EN && ovf;
    sum     = sum_raw;
    if (sat_hit) begin
      sum = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end

    acc_op = ACC_HOLD;
    if (pe.clr) begin
      acc_op = ACC_FLUSH;
    end else if (p_vld) begin
      acc_op = p_last ? ACC_TILE_END : ACC_ADD;
    end
  end

  // Next state for accumulator, tile saturation, result and error flag.
  always_comb begin
    acc_d      = acc_q;
    tile_sat_d = tile_sat_q;
    res_d      = res_q;
    res_sat_d  = res_sat_q;
    res_vld_d  = 1'b0;
    err_d      = pe.clr ? 1'b0 : (err_q | mis);

    unique case (acc_op)
      ACC_FLUSH: begin
        acc_d      = '0;
        tile_sat_d = 1'b0;
      end
      ACC_ADD: begin
        acc_d      = sum;
        tile_sat_d = tile_sat_q | sat_hit;
      end
      // Restarting from zero here lets the next tile follow with no gap.
      ACC_TILE_END: begin
        res_d      = sum;
        res_sat_d  = tile_sat_q | sat_hit;
        res_vld_d  = 1'b1;
        acc_d      = '0;
        tile_sat_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Accumulator, result and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      tile_sat_q <= 1'b0;
      res_q      <= '0;
      res_sat_q  <= 1'b0;
      res_vld_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      tile_sat_q <= tile_sat_d;
      res_q      <= res_d;
      res_sat_q  <= res_sat_d;
      res_vld_q  <= res_vld_d;
      err_q      <= err_d;
    end
  end

  assign pe.res_out = res_q;
  assign pe.res_vld = res_vld_q;
  assign pe.res_sat = res_sat_q;
  assign pe.err_mis = err_q;

endmodule

// File: tb/tb_systolic_pe_os.sv
// Directed bench for systolic_pe_os across several parameter sets.
module tb_systolic_pe_os;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  systolic_pe_os_if #(.A_W(8), .B_W(8), .ACC_W(24)) i_l1 ();
  systolic_pe_os_if #(.A_W(8), .B_W(8), .ACC_W(16)) i_sat ();
  systolic_pe_os_if #(.A_W(8), .B_W(8), .ACC_W(16)) i_wrap ();
  systolic_pe_os_if #(.A_W(8), .B_W(8), .ACC_W(24)) i_l3 ();
  systolic_pe_os_if #(.A_W(8), .B_W(8), .ACC_W(24)) i_l2 ();

  systolic_pe_os #(.A_W(8), .B_W(8), .ACC_W(24), .MUL_LAT(1), .SAT_EN(1'b1))
    u_l1 (.clk(clk), .rst_n(rst_n), .pe(i_l1));
  systolic_pe_os #(.A_W(8), .B_W(8), .ACC_W(16), .MUL_LAT(1), .SAT_EN(1'b1))
    u_sat (.clk(clk), .rst_n(rst_n), .pe(i_sat));
  systolic_pe_os #(.A_W(8), .B_W(8), .ACC_W(16), .MUL_LAT(1), .SAT_EN(1'b0))
    u_wrap (.clk(clk), .rst_n(rst_n), .pe(i_wrap));
  systolic_pe_os #(.A_W(8), .B_W(8), .ACC_W(24), .MUL_LAT(3), .SAT_EN(1'b1))
    u_l3 (.clk(clk), .rst_n(rst_n), .pe(i_l3));
  systolic_pe_os #(.A_W(8), .B_W(8), .ACC_W(24), .MUL_LAT(2), .SAT_EN(1'b1))
    u_l2 (.clk(clk), .rst_n(rst_n), .pe(i_l2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv_l1(input logic av, input logic bv, input logic last,
                        input int a, input int b);
    i_l1.a_vld_in = av; i_l1.b_vld_in = bv; i_l1.a_last_in = last;
    i_l1.a_in = 8'(a);  i_l1.b_in = 8'(b);
  endtask

  task automatic drv_sw(input logic av, input logic bv, input logic last,
                        input int a, input int b);
    i_sat.a_vld_in  = av; i_sat.b_vld_in  = bv; i_sat.a_last_in  = last;
    i_sat.a_in  = 8'(a);  i_sat.b_in  = 8'(b);
    i_wrap.a_vld_in = av; i_wrap.b_vld_in = bv; i_wrap.a_last_in = last;
    i_wrap.a_in = 8'(a);  i_wrap.b_in = 8'(b);
  endtask

  task automatic drv_l3(input logic av, input logic bv, input logic last,
                        input int a, input int b);
    i_l3.a_vld_in = av; i_l3.b_vld_in = bv; i_l3.a_last_in = last;
    i_l3.a_in = 8'(a);  i_l3.b_in = 8'(b);
  endtask

  task automatic drv_l2(input logic av, input logic bv, input logic last,
                        input int a, input int b);
    i_l2.a_vld_in = av; i_l2.b_vld_in = bv; i_l2.a_last_in = last;
    i_l2.a_in = 8'(a);  i_l2.b_in = 8'(b);
  endtask

  // One MUL_LAT=3 cycle: drive, clock, then the forwarded outputs must equal
  // what was just driven and res_vld must match exp_rv.
  task automatic step_l3(input logic av, input logic bv, input logic last,
                         input int a, input int b, input logic exp_rv);
    drv_l3(av, bv, last, a, b);
    tick();
    chk_v("l3_a_out",      int'(i_l3.a_out), a);
    chk_v("l3_b_out",      int'(i_l3.b_out), b);
    chk_b("l3_a_vld_out",  i_l3.a_vld_out,  av);
    chk_b("l3_a_last_out", i_l3.a_last_out, last);
    chk_b("l3_b_vld_out",  i_l3.b_vld_out,  bv);
    chk_b("l3_res_vld",    i_l3.res_vld,    exp_rv);
  endtask

  initial begin
    rst_n = 1'b0;
    i_l1.clr = 1'b0; i_sat.clr = 1'b0; i_wrap.clr = 1'b0;
    i_l3.clr = 1'b0; i_l2.clr = 1'b0;
    drv_l1(1'b1, 1'b1, 1'b1, 9, 9);
    drv_sw(1'b0, 1'b0, 1'b0, 0, 0);
    drv_l3(1'b0, 1'b0, 1'b0, 0, 0);
    drv_l2(1'b0, 1'b0, 1'b0, 0, 0);

    // Reset holds everything at zero even with live inputs.
    tick(); tick();
    chk_v("rst_a_out",   int'(i_l1.a_out), 0);
    chk_b("rst_a_vld",   i_l1.a_vld_out, 1'b0);
    chk_v("rst_res_out", int'(i_l1.res_out), 0);
    chk_b("rst_res_vld", i_l1.res_vld, 1'b0);
    chk_b("rst_err_mis", i_l1.err_mis, 1'b0);
    drv_l1(1'b0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_b("rst_rel_res_vld", i_l1.res_vld, 1'b0);

    // Tile 3*4 + 5*6 + -2*7 = 28 with MUL_LAT=1.
    drv_l1(1'b1, 1'b1, 1'b0, 3, 4);   tick();
    drv_l1(1'b1, 1'b1, 1'b0, 5, 6);   tick();
    drv_l1(1'b1, 1'b1, 1'b1, -2, 7);  tick();
    chk_v("t1_a_fwd",   int'(i_l1.a_out), -2);
    chk_b("t1_last_fwd", i_l1.a_last_out, 1'b1);
    chk_b("t1_rv_early", i_l1.res_vld, 1'b0);
    drv_l1(1'b0, 1'b0, 1'b0, 0, 0);   tick();
    chk_b("t1_rv",      i_l1.res_vld, 1'b1);
    chk_v("t1_res",     int'(i_l1.res_out), 28);
    chk_b("t1_sat",     i_l1.res_sat, 1'b0);
    tick();
    chk_b("t1_rv_pulse", i_l1.res_vld, 1'b0);
    chk_v("t1_res_hold", int'(i_l1.res_out), 28);

    // Back-to-back tiles {2*3} then {-1*1, 4*4}.
    drv_l1(1'b1, 1'b1, 1'b1, 2, 3);   tick();
    drv_l1(1'b1, 1'b1, 1'b0, -1, 1);  tick();
    chk_b("b2b_rv1",  i_l1.res_vld, 1'b1);
    chk_v("b2b_res1", int'(i_l1.res_out), 6);
    drv_l1(1'b1, 1'b1, 1'b1, 4, 4);   tick();
    chk_b("b2b_rv_gap", i_l1.res_vld, 1'b0);
    drv_l1(1'b0, 1'b0, 1'b0, 0, 0);   tick();
    chk_b("b2b_rv2",  i_l1.res_vld, 1'b1);
    chk_v("b2b_res2", int'(i_l1.res_out), 15);

    // Four 127*127 into a 16-bit accumulator: clamp vs wrap (64516-65536).
    drv_sw(1'b1, 1'b1, 1'b0, 127, 127); tick();
    drv_sw(1'b1, 1'b1, 1'b0, 127, 127); tick();
    drv_sw(1'b1, 1'b1, 1'b0, 127, 127); tick();
    drv_sw(1'b1, 1'b1, 1'b1, 127, 127); tick();
    drv_sw(1'b0, 1'b0, 1'b0, 0, 0);     tick();
    chk_b("sat_rv",   i_sat.res_vld, 1'b1);
    chk_v("sat_res",  int'(i_sat.res_out), 32767);
    chk_b("sat_flag", i_sat.res_sat, 1'b1);
    chk_b("wrap_rv",  i_wrap.res_vld, 1'b1);
    chk_v("wrap_res", int'(i_wrap.res_out), -1020);
    chk_b("wrap_flag", i_wrap.res_sat, 1'b0);
    // Length-1 tile afterwards: saturation flag must not leak across tiles.
    drv_sw(1'b1, 1'b1, 1'b1, -3, 5); tick();
    drv_sw(1'b0, 1'b0, 1'b0, 0, 0);  tick();
    chk_v("sat_next_res",  int'(i_sat.res_out), -15);
    chk_b("sat_next_flag", i_sat.res_sat, 1'b0);
    chk_v("wrap_next_res", int'(i_wrap.res_out), -15);

    // MUL_LAT=3 stream with gaps: 1+4+9+16+25 = 55, res_vld 4 cycles after last issue.
    step_l3(1'b1, 1'b1, 1'b0, 1, 1, 1'b0);
    step_l3(1'b0, 1'b0, 1'b0, 7, -3, 1'b0);
    step_l3(1'b1, 1'b1, 1'b0, 2, 2, 1'b0);
    step_l3(1'b1, 1'b1, 1'b0, 3, 3, 1'b0);
    step_l3(1'b0, 1'b0, 1'b1, 9, 9, 1'b0);
    step_l3(1'b1, 1'b1, 1'b0, 4, 4, 1'b0);
    step_l3(1'b1, 1'b1, 1'b1, 5, 5, 1'b0);
    step_l3(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    step_l3(1'b0, 1'b0, 1'b0, -8, 6, 1'b0);
    step_l3(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    chk_v("l3_res", int'(i_l3.res_out), 55);
    chk_b("l3_err", i_l3.err_mis, 1'b0);

    // MUL_LAT=2: a reference tile, then clr kills an in-flight last product.
    drv_l2(1'b1, 1'b1, 1'b1, 2, 5); tick();
    drv_l2(1'b0, 1'b0, 1'b0, 0, 0); tick();
    chk_b("l2_rv_early", i_l2.res_vld, 1'b0);
    tick();
    chk_b("l2_rv",  i_l2.res_vld, 1'b1);
    chk_v("l2_res", int'(i_l2.res_out), 10);
    drv_l2(1'b1, 1'b1, 1'b1, 9, 9); tick();
    drv_l2(1'b0, 1'b0, 1'b0, 0, 0); i_l2.clr = 1'b1; tick();
    i_l2.clr = 1'b0;
    chk_b("clr_rv_a", i_l2.res_vld, 1'b0);
    tick();
    chk_b("clr_rv_b", i_l2.res_vld, 1'b0);
    chk_v("clr_res_hold", int'(i_l2.res_out), 10);
    tick();
    chk_b("clr_rv_c", i_l2.res_vld, 1'b0);
    // Issue in the same cycle as clr is discarded too.
    drv_l2(1'b1, 1'b1, 1'b1, 6, 6); i_l2.clr = 1'b1; tick();
    i_l2.clr = 1'b0;
    drv_l2(1'b0, 1'b0, 1'b0, 0, 0); tick(); tick();
    chk_b("clr_iss_rv", i_l2.res_vld, 1'b0);
    tick();
    chk_b("clr_iss_rv2", i_l2.res_vld, 1'b0);
    chk_v("clr_iss_res", int'(i_l2.res_out), 10);
    drv_l2(1'b1, 1'b1, 1'b1, 7, 7); tick();
    drv_l2(1'b0, 1'b0, 1'b0, 0, 0); tick(); tick();
    chk_b("l2_post_rv",  i_l2.res_vld, 1'b1);
    chk_v("l2_post_res", int'(i_l2.res_out), 49);

    // Mismatched valids: sticky error, no contribution to the tile.
    drv_l1(1'b1, 1'b1, 1'b0, 5, 5);     tick();
    drv_l1(1'b1, 1'b0, 1'b0, 100, 100); tick();
    chk_b("mis_err", i_l1.err_mis, 1'b1);
    drv_l1(1'b1, 1'b1, 1'b1, 1, 1);     tick();
    drv_l1(1'b0, 1'b0, 1'b0, 0, 0);
    chk_b("mis_sticky", i_l1.err_mis, 1'b1);
    tick();
    chk_b("mis_rv",  i_l1.res_vld, 1'b1);
    chk_v("mis_res", int'(i_l1.res_out), 26);
    i_l1.clr = 1'b1; tick();
    i_l1.clr = 1'b0;
    chk_b("mis_clr", i_l1.err_mis, 1'b0);
    chk_v("mis_clr_res_hold", int'(i_l1.res_out), 26);

    // Asynchronous reset mid-tile drops outputs immediately and the partial sum.
    drv_l1(1'b1, 1'b1, 1'b0, 3, 3); tick();
    drv_l1(1'b1, 1'b0, 1'b0, 1, 1); tick();
    chk_b("ar_err_pre", i_l1.err_mis, 1'b1);
    drv_l1(1'b0, 1'b0, 1'b0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_v("ar_res",   int'(i_l1.res_out), 0);
    chk_b("ar_err",   i_l1.err_mis, 1'b0);
    chk_v("ar_a_out", int'(i_l1.a_out), 0);
    chk_b("ar_a_vld", i_l1.a_vld_out, 1'b0);
    tick();
    rst_n = 1'b1;
    drv_l1(1'b1, 1'b1, 1'b1, 2, 2); tick();
    drv_l1(1'b0, 1'b0, 1'b0, 0, 0);
    chk_b("ar_rv_early", i_l1.res_vld, 1'b0);
    tick();
    chk_b("ar_rv",  i_l1.res_vld, 1'b1);
    chk_v("ar_res_new", int'(i_l1.res_out), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
